// File: rtl/ecc_alu.sv
// ecc_alu: modular add / multiply / inverse responder on the ECC signing datapath.
// Operands arrive on the shared RAM read port; the result returns with a one-cycle valid pulse.
module ecc_alu #(
  parameter int WID   = 256,
  parameter int OPLAT = 2
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           aen,
  input  logic [1:0]     aop,
  input  logic [WID-1:0] ramrd,
  input  logic [WID-1:0] modn,
  output logic [WID-1:0] adi,
  output logic           adivld,
  output logic           abusy
);

  localparam int         CW     = $clog2(WID) + 2;
  localparam logic [1:0] OP_FA  = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_INV = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_CAPA = 3'd2,
    S_CAPB = 3'd3,
    S_ADD  = 3'd4,
    S_MUL  = 3'd5,
    S_INV  = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic [WID-1:0]  r_a;
  logic [WID-1:0]  r_b;
  logic [WID-1:0]  r_u;
  logic [WID-1:0]  r_v;
  logic [WID-1:0]  r_x1;
  logic [WID-1:0]  r_x2;
  logic [WID+1:0]  r_acc;
  logic [WID+1:0]  w_acc_next;
  logic [WID-1:0]  r_adi;
  logic            r_vld;
  logic            r_busy;
  logic            w_inv_end;
  logic [WID-1:0]  w_inv_res;

  function automatic logic [WID-1:0] mod_add(input logic [WID-1:0] a, input logic [WID-1:0] b,
                                             input logic [WID-1:0] n);
    logic [WID:0] s;
    s = {1'b0, a} + {1'b0, b};
    s = (s >= {1'b0, n}) ? s - {1'b0, n} : s;
    return s[WID-1:0];
  endfunction

  // a - b mod n for a, b < n; the wrap branch stays below n so WID bits suffice.
  function automatic logic [WID-1:0] mod_sub(input logic [WID-1:0] a, input logic [WID-1:0] b,
                                             input logic [WID-1:0] n);
    return (a >= b) ? a - b : a + (n - b);
  endfunction

  function automatic logic [WID-1:0] mod_half(input logic [WID-1:0] x, input logic [WID-1:0] n);
    logic [WID:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, n}) : {1'b0, x};
    s = s >> 1;
    return s[WID-1:0];
  endfunction

  function automatic logic [WID+1:0] mul_step(input logic [WID+1:0] acc, input logic [WID-1:0] a,
                                              input logic b_bit, input logic [WID-1:0] n);
    logic [WID+1:0] t;
    logic [WID+1:0] nn;
    nn = {2'b00, n};
    t  = acc << 1;
    t  = (t >= nn) ? t - nn : t;
    t  = b_bit ? t + {2'b00, a} : t;
    t  = (t >= nn) ? t - nn : t;
    return t;
  endfunction

  assign w_acc_next = mul_step(r_acc, r_a, r_b[WID-1], modn);
  assign w_inv_end  = (r_u == WID'(1)) || (r_v == WID'(1)) || (r_u == '0) || (r_v == '0);

  // Inverse result: a zero u or v means gcd(A, n) != 1, which reports 0.
  always_comb begin
    w_inv_res = '0;
    if (r_u == WID'(1)) begin
      w_inv_res = r_x1;
    end else if (r_v == WID'(1)) begin
      w_inv_res = r_x2;
    end else begin
      w_inv_res = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = aen ? ((OPLAT > 1) ? S_WAIT : S_CAPA) : S_IDLE;
      S_WAIT: w_next = (r_cnt == CW'(1)) ? S_CAPA : S_WAIT;
      S_CAPA: begin
        case (r_op)
          OP_MUL:  w_next = S_CAPB;
          OP_INV:  w_next = S_INV;
          default: w_next = S_ADD;
        endcase
      end
      S_CAPB:  w_next = S_MUL;
      S_ADD:   w_next = S_DONE;
      S_MUL:   w_next = (r_cnt == CW'(1)) ? S_DONE : S_MUL;
      S_INV:   w_next = w_inv_end ? S_DONE : S_INV;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The add happens in the cycle B sits on ramrd, so FA needs no separate B capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_op   <= 2'b00;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_u    <= '0;
      r_v    <= '0;
      r_x1   <= '0;
      r_x2   <= '0;
      r_acc  <= '0;
      r_adi  <= '0;
      r_vld  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (aen) begin
            r_op   <= aop;
            r_cnt  <= CW'(OPLAT - 1);
            r_busy <= 1'b1;
          end
        end
        S_WAIT: r_cnt <= r_cnt - CW'(1);
        S_CAPA: begin
          r_a   <= ramrd;
          r_u   <= ramrd;
          r_v   <= modn;
          r_x1  <= WID'(1);
          r_x2  <= '0;
          r_acc <= '0;
        end
        S_CAPB: begin
          r_b   <= ramrd;
          r_cnt <= CW'(WID);
        end
        S_ADD: begin
          r_adi <= (r_op == OP_FA) ? mod_add(r_a, ramrd, modn) : '0;
          r_vld <= 1'b1;
        end
        S_MUL: begin
          r_acc <= w_acc_next;
          r_b   <= {r_b[WID-2:0], 1'b0};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_adi <= w_acc_next[WID-1:0];
            r_vld <= 1'b1;
          end
        end
        S_INV: begin
          if (w_inv_end) begin
            r_adi <= w_inv_res;
            r_vld <= 1'b1;
          end else if (!r_u[0]) begin
            r_u  <= r_u >> 1;
            r_x1 <= mod_half(r_x1, modn);
          end else if (!r_v[0]) begin
            r_v  <= r_v >> 1;
            r_x2 <= mod_half(r_x2, modn);
          end else if (r_u >= r_v) begin
            r_u  <= r_u - r_v;
            r_x1 <= mod_sub(r_x1, r_x2, modn);
          end else begin
            r_v  <= r_v - r_u;
            r_x2 <= mod_sub(r_x2, r_x1, modn);
          end
        end
        S_DONE: begin
          r_vld  <= 1'b0;
          r_busy <= 1'b0;
          r_op   <= 2'b00;
          r_cnt  <= '0;
          r_a    <= '0;
          r_b    <= '0;
          r_u    <= '0;
          r_v    <= '0;
          r_x1   <= '0;
          r_x2   <= '0;
          r_acc  <= '0;
        end
        default: begin
          r_vld  <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign adi    = r_adi;
  assign adivld = r_vld;
  assign abusy  = r_busy;

endmodule

// File: doc/ecc_alu.md
Name: ecc_alu

Overview:
- Modular arithmetic responder on the ECC signing datapath.
- Answers the ALU command interface driven by the signature sequencers (aen/aop out, adi/adivld back).
- Fetches one or two operands from the shared working RAM read port and computes a+b, a*b or a^-1 mod n.
- Returns the registered result with a one-cycle valid pulse; the sequencer writes it back to RAM.

Parameters:
- WID, 256, operand/result/modulus width in bits.
- OPLAT, 2, cycles from the aen cycle to the cycle operand A is present on ramrd. Operand B follows one cycle later. Legal range 1..3.

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- aen  in  1  command strobe, one-cycle pulse
- aop  in  2  opcode sampled with aen: 00 FA (add), 01 MUL, 10 INV, 11 reserved
- ramrd  in  WID  working-RAM read data (operand source)
- modn  in  WID  modulus n, odd, >2, static while busy
- adi  out  WID  result, registered
- adivld  out  1  result-valid pulse, one cycle
- abusy  out  1  high from the cycle after an accepted aen through the adivld cycle

Behaviour:
- Reset (rstn low, asynchronous): adi=0, adivld=0, abusy=0, FSM=IDLE, all datapath registers 0.
- Reset asserted mid-operation aborts immediately; no adivld is produced afterwards.
- FSM states: IDLE, WAIT, CAPA, CAPB, ADD, MUL, INV, DONE.
- Acceptance: aen=1 in IDLE accepts the command at cycle T and latches aop.
  - aen while abusy=1 is ignored; the in-flight operation is unaffected.
  - aen in the DONE cycle is ignored.
- Operand capture:
  - WAIT counts OPLAT-1 cycles.
  - A = ramrd at T+OPLAT (CAPA).
  - B = ramrd at T+OPLAT+1 (CAPB).
  - INV skips CAPB.
- ADD (FA): s = A+B in WID+1 bits; result = s-n if s>=n else s. adivld=1 at T+OPLAT+2.
- MUL: interleaved MSB-first shift-add, one bit of B per cycle, WID cycles.
  - Each cycle: acc = 2*acc mod n, then if the B bit is 1, acc = acc+A mod n.
  - Accumulator is WID+2 bits wide; reduction is by conditional subtract after each step.
  - adivld=1 at exactly T+OPLAT+WID+2.
- INV: binary extended Euclid, one micro-step per cycle. Init u=A, v=n, x1=1, x2=0. Loop until u==1 or v==1:
  - If u is even: u=u/2; x1 = x1/2 if x1 is even, else (x1+n)/2 using WID+1 bits.
  - Else if v is even: same halving applied to v and x2.
  - Else if u>=v: u=u-v, x1=x1-x2 mod n.
  - Else: v=v-u, x2=x2-x1 mod n.
  - Result = x1 if u==1, else x2.
  - Latency is data dependent; adivld at or before T+OPLAT+4*WID+4.
  - A==0: result 0, adivld at T+OPLAT+2. Same result and timing when gcd(A,n)!=1, detected by u==0 or v==0.
- Reserved opcode 11: result 0, same timing as FA.
- Result hand-off:
  - DONE drives adivld=1 for exactly one cycle and loads adi in the same cycle.
  - adi holds its value until the next DONE.
  - abusy drops to 0 in the cycle after adivld; the next aen is accepted from that cycle.
- Operands must be <n. If not, the result value is unspecified, but adivld timing still holds.
- A and B registers are cleared to 0 on return to IDLE.

Test Plan:
- WID=8, OPLAT=2, n=251, aen with aop=00, A=200, B=100 -> adi=49, adivld exactly 4 cycles after aen, abusy high in between.
- Same setup, aop=01, A=20, B=30 -> adi=98, adivld exactly WID+4=12 cycles after aen. A=250, B=250 -> adi=1.
- aop=10, A=3 -> adi=84. A=1 -> adi=1. A=250 -> adi=250. A=0 -> adi=0 at aen+4. Every INV latency must be <=40 cycles.
- Second aen issued 3 cycles into a MUL with a different opcode -> ignored; the single adivld carries only the MUL result. aen in the cycle after adivld -> accepted.
- rstn pulsed low mid-INV -> adi=0, adivld=0, abusy=0 at once; a new FA 200+100 after release -> 49.
- WID=256, OPLAT=2, n=secp256k1 order, 1000 random A -> INV(A)*A mod n == 1, checked with the MUL path and a reference model; latency bound holds for every vector.
